fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Phase sequencer and instruction-fetch master for the multi-cycle core. Drives the one-hot phase strobes (`phase_f`, `phase_r`, `phase_x`, `phase_w`) to the program counter and the datapath. Reads the next fetch address from the program counter's `pc` output, runs a request/acknowledge read on the instruction memory, and holds the fetched word in the instruction register for decode.

## Interface
- `TIMEOUT`, default 255: maximum FETCH wait cycles before error; range 1..255. Only used when `FETCH_TIMEOUT_EN` is defined.
- `clk` in 1: clock.
- `n_rst` in 1: reset, synchronous, active-low.
- `hlt` in 1: halt request from decode; sampled only in WRITE.
- `pc` in 32: next-instruction address from the program counter.
- `imem_req` out 1: instruction read request.
- `imem_addr` out 32: word-aligned read address.
- `imem_ack` in 1: read data valid.
- `imem_rdata` in 32: read data.
- `ir` out 32: instruction register.
- `phase_f` out 1: fetch-complete strobe.
- `phase_r` out 1: register-read phase.
- `phase_x` out 1: execute phase.
- `phase_w` out 1: write-back phase.
- `halted` out 1: high in HALT.
- `fetch_err` out 1: sticky fetch-timeout flag; constant 0 without `FETCH_TIMEOUT_EN`.

## Operation
- States: IDLE, FETCH, READ, EXEC, WRITE, HALT. The state is registered, and all outputs decode from the state register plus `imem_ack`.
- Reset (`n_rst`=0 at a clk edge) forces the following values:
  - state = IDLE, `fetch_addr` = 0, `ir` = 0, `fetch_err` = 0, timeout counter = 0.
  - Outputs go low: `imem_req`, all phase strobes, `halted`.
  - Reset takes priority over every other event.
- IDLE: lasts one cycle. Captures `fetch_addr <= pc & 32'hFFFFFFFC`, then goes to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`fetch_addr`, both held stable until ack.
  - On a cycle with `imem_ack`=1: `phase_f`=1 for that cycle only, `ir <= imem_rdata`, next state READ.
  - Without ack: remain in FETCH with `phase_f`=0.
- READ: `phase_r`=1, then EXEC.
- EXEC: `phase_x`=1, then WRITE.
- WRITE:
  - `phase_w`=1.
  - If `hlt`=1, go to HALT.
  - Otherwise capture `fetch_addr <= pc & 32'hFFFFFFFC` (branch target or sequential address as presented by the program counter) and go to FETCH.
- HALT: `halted`=1 and all other strobes 0. Only reset exits HALT.
- Phase strobes are mutually exclusive; at most one is high in any cycle.
- `imem_ack` outside FETCH is ignored, and `ir` is unchanged.
- `ir` changes only on an acknowledged FETCH cycle. It is stable through READ, EXEC and WRITE.
- Misaligned `pc` is silently aligned; bits [1:0] of `imem_addr` are always 0.

## Timing
- `imem_ack` may arrive in the first FETCH cycle (zero-wait). Minimum instruction period is 4 cycles: FETCH, READ, EXEC, WRITE.
- With N wait cycles the period is 4+N, and FETCH occupies 1+N cycles.
- `phase_f` is asserted exactly once per instruction, in the ack cycle. The program counter therefore advances exactly once per fetch.
- After reset release: IDLE (1 cycle), then `imem_req` rises in the 2nd cycle.
- The address captured in WRITE appears on `imem_addr` in the following cycle.
- `hlt` in WRITE: HALT is entered on the next cycle, and no further `imem_req` is issued.

## Configuration
- Macro `FETCH_TIMEOUT_EN`.
- When defined:
  - An 8-bit counter clears on FETCH entry and increments each FETCH cycle without ack.
  - If it reaches `TIMEOUT` without ack: `fetch_err` <= 1 (sticky until reset), `imem_req` drops, and the state goes to HALT.
  - An ack in the same cycle the counter reaches `TIMEOUT` wins, giving normal completion.
- When undefined: no counter exists, FETCH waits indefinitely, and `fetch_err` is tied to 0.

## Test plan
- Reset, then zero-wait memory with ack always 1 and `pc` sequence 0,4,8:
  - `imem_addr` = 0,4,8 on FETCH cycles.
  - Strobes repeat f,r,x,w every 4 cycles.
  - `ir` = rdata for each address.
- Ack delayed 3 cycles, rdata=0xDEADBEEF:
  - `imem_req` high 4 cycles with `imem_addr` stable.
  - `phase_f` high only in cycle 4.
  - `ir`=0xDEADBEEF from READ onward.
- Branch: `pc`=0x103 during WRITE -> next FETCH `imem_addr`=0x100.
- `hlt`=1 in WRITE -> `halted`=1 next cycle. No `imem_req` for 20 cycles, and stray acks leave `ir` unchanged.
- Reset asserted mid-FETCH (waiting) -> next cycle all outputs 0 and state IDLE. After release, `imem_req` rises in the 2nd cycle.
- With `FETCH_TIMEOUT_EN` and `TIMEOUT`=5, ack never arrives:
  - `fetch_err`=1 and `halted`=1 after 5 FETCH cycles.
  - Repeat with ack on the 5th cycle -> normal READ, `fetch_err`=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Phase sequencer and instruction-fetch master: IDLE -> FETCH -> READ -> EXEC -> WRITE, with HALT.
// Define FETCH_TIMEOUT_EN to add a fetch wait-cycle limit that raises a sticky fetch_err and halts.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hlt,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        phase_f,
  output logic        phase_r,
  output logic        phase_x,
  output logic        phase_w,
  output logic        halted,
  output logic        fetch_err,
  output logic [2:0]  state_dbg
);

  // Memory handshake: imem_req/imem_addr are held while in FETCH; a cycle with
  // imem_req=1 and imem_ack=1 transfers imem_rdata into ir and ends the fetch.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_READ  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state;
  logic [31:0] fetch_addr;

`ifdef FETCH_TIMEOUT_EN
  // Counter holds the number of ack-less FETCH cycles already completed, so the
  // cycle that would make it reach TIMEOUT is the one that trips the error.
  localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       err_q;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      fetch_addr <= 32'd0;
      ir         <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt   <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          fetch_addr <= pc & ALIGN_MASK;
          state      <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt   <= 8'd0;
`endif
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_READ;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == LIMIT_M1) begin
            err_q <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        S_READ:  state <= S_EXEC;
        S_EXEC:  state <= S_WRITE;
        S_WRITE: begin
          if (hlt) begin
            state <= S_HALT;
          end else begin
            fetch_addr <= pc & ALIGN_MASK;
            state      <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt   <= 8'd0;
`endif
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = fetch_addr;
  assign phase_f   = (state == S_FETCH) && imem_ack;
  assign phase_r   = (state == S_READ);
  assign phase_x   = (state == S_EXEC);
  assign phase_w   = (state == S_WRITE);
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-level model.
module tb_fetch_sequencer;

  localparam int TMO = 5;

  logic        clk;
  logic        n_rst;
  logic        hlt;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        phase_f, phase_r, phase_x, phase_w;
  logic        halted;
  logic        fetch_err;
  logic [2:0]  state_dbg;

  logic        use_mem;
  logic [31:0] rdata_drv;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .hlt        (hlt),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .phase_f    (phase_f),
    .phase_r    (phase_r),
    .phase_x    (phase_x),
    .phase_w    (phase_w),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = use_mem ? memf(imem_addr) : rdata_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the active edge and stay put until the next one.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, phase_f, phase_r, phase_x, phase_w};
  endfunction

  // ---------------- behavioural model ----------------
  // m_pos: 0 = before the first fetch after reset, 1..4 = slot of the
  // current instruction (fetch, read, execute, write).
  int          m_pos   = 0;
  bit          m_halt  = 1'b0;
  bit          m_err   = 1'b0;
  int          m_waits = 0;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_ir    = 32'd0;

  always @(negedge clk) begin
    logic [3:0] exp_s;
    exp_s = 4'd0;
    if (!m_halt && m_pos >= 1) exp_s = 4'b1000 >> (m_pos - 1);
    if (m_pos == 1 && !imem_ack) exp_s[3] = 1'b0;
    chk("m_strobes", strobes(), {28'd0, exp_s});
    chk("m_req", {31'd0, imem_req}, {31'd0, !m_halt && m_pos == 1});
    chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
    chk("m_err", {31'd0, fetch_err}, {31'd0, m_err});
    chk("m_ir", ir, m_ir);
    if (!m_halt && m_pos == 1) chk("m_addr", imem_addr, m_addr);

    // advance to what the next edge must produce
    if (!n_rst) begin
      m_pos = 0; m_halt = 1'b0; m_err = 1'b0; m_waits = 0;
      m_addr = 32'd0; m_ir = 32'd0;
    end else if (!m_halt) begin
      if (m_pos == 0) begin
        m_addr = {pc[31:2], 2'b00}; m_pos = 1; m_waits = 0;
      end else if (m_pos == 1) begin
        if (imem_ack) begin
          m_ir = imem_rdata; m_pos = 2;
        end else begin
          m_waits++;
`ifdef FETCH_TIMEOUT_EN
          if (m_waits == TMO) begin
            m_halt = 1'b1; m_err = 1'b1;
          end
`endif
        end
      end else if (m_pos < 4) begin
        m_pos++;
      end else if (hlt) begin
        m_halt = 1'b1;
      end else begin
        m_addr = {pc[31:2], 2'b00}; m_pos = 1; m_waits = 0;
      end
    end
  end

  // ---------------- directed + random driver ----------------
  initial begin
    n_rst = 1'b0; hlt = 1'b0; pc = 32'd0; imem_ack = 1'b0;
    rdata_drv = 32'd0; use_mem = 1'b1;

    next_cycle();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_outs", {strobes()[3:0], halted, fetch_err}, 32'd0);

    // zero-wait fetches, pc 0,4,8,12 then a branch to 0x103 in WRITE
    for (int k = 0; k <= 16; k++) begin
      next_cycle();
      n_rst = 1'b1; imem_ack = 1'b1; hlt = 1'b0;
      pc = (k == 16) ? 32'h0000_0103 : 32'(4 * ((k + 3) / 4));
      @(negedge clk);
      if (k == 0) begin
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        chk("idle_strobes", strobes(), 32'd0);
      end else begin
        int p;
        p = (k - 1) % 4;
        chk("zw_strobes", strobes(), 32'(4'b1000 >> p));
        chk("zw_req", {31'd0, imem_req}, {31'd0, p == 0});
        if (p == 0) chk("zw_addr", imem_addr, 32'(4 * ((k - 1) / 4)));
        if (p == 1) chk("zw_ir", ir, memf(32'(4 * ((k - 1) / 4))));
      end
    end

    // three wait cycles at the branch target, then 0xDEADBEEF
    for (int k = 17; k <= 20; k++) begin
      next_cycle();
      use_mem = 1'b0; imem_ack = (k == 20);
      rdata_drv = (k == 20) ? 32'hDEAD_BEEF : $urandom;
      pc = $urandom; hlt = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("dly_req", {31'd0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr, 32'h0000_0100);
      chk("dly_pf", {31'd0, phase_f}, {31'd0, k == 20});
      chk("dly_ir_hold", ir, memf(32'd12));
    end
    for (int k = 21; k <= 23; k++) begin
      next_cycle();
      imem_ack = 1'($urandom_range(0, 1)); rdata_drv = $urandom; pc = $urandom;
      hlt = (k == 23) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("dly_ir", ir, 32'hDEAD_BEEF);
      chk("dly_phase", strobes(), 32'(4'b0100 >> (k - 21)));
    end

    // halted: no requests, stray acks ignored
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      imem_ack = 1'b1; rdata_drv = $urandom; pc = $urandom;
      hlt = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_ir", ir, 32'hDEAD_BEEF);
      chk("halt_strobes", strobes(), 32'd0);
    end

    // reset while waiting in FETCH
    next_cycle(); n_rst = 1'b0; hlt = 1'b0; imem_ack = 1'b0;
    next_cycle(); n_rst = 1'b1; pc = 32'h0000_0022;
    next_cycle(); pc = $urandom;
    @(negedge clk);
    chk("mf_req", {31'd0, imem_req}, 32'd1);
    chk("mf_addr", imem_addr, 32'h0000_0020);
    next_cycle(); n_rst = 1'b0;
    next_cycle(); n_rst = 1'b1; pc = 32'h0000_0047;
    @(negedge clk);
    chk("mf_rst_outs", {strobes()[3:0], imem_req, halted, fetch_err}, 32'd0);
    chk("mf_rst_ir", ir, 32'd0);
    next_cycle(); pc = $urandom;
    @(negedge clk);
    chk("mf_rel_req", {31'd0, imem_req}, 32'd1);
    chk("mf_rel_addr", imem_addr, 32'h0000_0044);

`ifdef FETCH_TIMEOUT_EN
    // that FETCH was cycle 1; four more without ack, then timeout
    for (int i = 2; i <= TMO; i++) begin
      next_cycle();
      @(negedge clk);
      chk("to_req", {31'd0, imem_req}, 32'd1);
      chk("to_halted", {31'd0, halted}, 32'd0);
    end
    next_cycle();
    @(negedge clk);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_halted_now", {31'd0, halted}, 32'd1);
    chk("to_req_drop", {31'd0, imem_req}, 32'd0);
    next_cycle(); n_rst = 1'b0;
    next_cycle(); n_rst = 1'b1; pc = 32'h0000_0080;
    for (int i = 1; i <= TMO; i++) begin
      next_cycle();
      imem_ack = (i == TMO); rdata_drv = 32'h0BAD_F00D;
      @(negedge clk);
      chk("ta_pf", {31'd0, phase_f}, {31'd0, i == TMO});
      chk("ta_req", {31'd0, imem_req}, 32'd1);
    end
    next_cycle(); imem_ack = 1'b0;
    @(negedge clk);
    chk("ta_read", strobes(), 32'b0100);
    chk("ta_err", {31'd0, fetch_err}, 32'd0);
    chk("ta_ir", ir, 32'h0BAD_F00D);
`else
    next_cycle(); imem_ack = 1'b1; rdata_drv = 32'h0BAD_F00D;
    next_cycle(); imem_ack = 1'b0;
    @(negedge clk);
    chk("na_read", strobes(), 32'b0100);
    chk("na_ir", ir, 32'h0BAD_F00D);
    chk("na_err", {31'd0, fetch_err}, 32'd0);
`endif

    // random traffic, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      n_rst     = m_halt ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) != 0);
      hlt       = ($urandom_range(0, 5) == 0);
      pc        = $urandom;
      imem_ack  = ($urandom_range(0, 2) != 0);
      rdata_drv = $urandom;
      use_mem   = 1'($urandom_range(0, 1));
    end

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
